hazard_scoreboard_unit: RTL and testbench

Parametrised load-use/long-latency hazard controller for the in-order pipeline, sitting beside the ID stage and driving the IF, IF_ID and ID_EXE control modes. A small scoreboard holds one entry per in-flight long-latency write, such as a load with memory wait states, mul or div. Each entry stays pending until a tagged completion arrives. The ID instruction stalls while any of its sources or its destination matches a pending entry, and also while the scoreboard is full.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 22 ++
 rtl/hazard_scoreboard_unit_sb_prio_enc.sv | 24 ++
 rtl/hazard_scoreboard_unit.sv | 151 +++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared pipeline control definitions: stage modes, stall levels,
// GPR address width and the default scoreboard depth.
package hazard_scoreboard_unit_pkg;

  // 32 general-purpose registers, x0 hard-wired to zero.
  localparam int GPR_ADDR_SPACE = 5;

  // Default number of in-flight long-latency writes tracked.
  localparam int SB_DEPTH_DEFAULT = 4;

  // Pipeline register control mode.
  typedef enum logic [1:0] {
    Normal = 2'b00,
    Stall  = 2'b01,
    Flush  = 2'b10
  } ctrl_mode_e;

  // Stall request levels.
  localparam logic On  = 1'b1;
  localparam logic Off = 1'b0;

endpackage

// File: rtl/hazard_scoreboard_unit_sb_prio_enc.sv
// Lowest-set-bit encoder: returns the index of the lowest asserted bit of
// vec_i and whether any bit is set. Used to pick the next free entry.
module sb_prio_enc #(
  parameter int W     = 4,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Load-use / long-latency hazard controller beside the ID stage. Tracks one
// scoreboard entry per in-flight long-latency write, stalls the ID
// instruction on RAW/WAW/structural hazards and drives the IF, IF_ID and
// ID_EXE control modes. Completions bypass through forwarding and never stall.
module hazard_scoreboard_unit
  import hazard_scoreboard_unit_pkg::*;
#(
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = SB_DEPTH_DEFAULT,
  parameter  int CNT_W   = 32,
  localparam int TAG_W   = $clog2(DEPTH)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                id_valid,
  input  logic [NUM_SRC*GPR_ADDR_SPACE-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]                  id_src_re,
  input  logic [GPR_ADDR_SPACE-1:0]           id_rd_addr,
  input  logic                                id_rd_we,
  input  logic                                id_long_lat,
  input  logic                                ex_flush,
  input  logic                                cmpl_valid,
  input  logic [TAG_W-1:0]                    cmpl_tag,
  output logic                                alloc_valid,
  output logic [TAG_W-1:0]                    alloc_tag,
  output logic [1:0]                          if_id_mode,
  output logic [1:0]                          id_exe_mode,
  output logic                                if_stall,
  output logic                                sb_full,
  output logic                                cmpl_err,
  output logic [CNT_W-1:0]                    stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Scoreboard state
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic [GPR_ADDR_SPACE-1:0] rd_q [DEPTH];
  logic                      cmpl_err_q, cmpl_err_d;
  logic [CNT_W-1:0]          stall_cycles_q, stall_cycles_d;

  // Per-entry decode
  logic [DEPTH-1:0] cmpl_sel;     // completion tag addresses this entry
  logic [DEPTH-1:0] live;         // pending and not completing this cycle
  logic [DEPTH-1:0] src_hit;      // a live entry feeds an enabled source
  logic [DEPTH-1:0] waw_hit;      // a live entry targets the same rd
  logic [DEPTH-1:0] alloc_onehot;

  logic                      rd_nz;
  logic                      long_write;
  logic                      struct_haz;
  logic                      hazard;
  logic                      cmpl_hit;
  logic [TAG_W-1:0]          free_idx;
  logic                      any_free;

  assign rd_nz      = (id_rd_addr != '0);
  assign long_write = id_long_lat && id_rd_we && rd_nz;

  genvar gi, gj;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [NUM_SRC-1:0] src_eq;

      assign cmpl_sel[gi] = cmpl_valid && (cmpl_tag == TAG_W'(gi));
      assign live[gi]     = valid_q[gi] && !cmpl_sel[gi];

      for (gj = 0; gj < NUM_SRC; gj++) begin : g_src
        assign src_eq[gj] = id_src_re[gj]
                         && (id_src_addr[gj*GPR_ADDR_SPACE +: GPR_ADDR_SPACE] != '0)
                         && (id_src_addr[gj*GPR_ADDR_SPACE +: GPR_ADDR_SPACE] == rd_q[gi]);
      end

      assign src_hit[gi]      = live[gi] && (|src_eq);
      assign waw_hit[gi]      = live[gi] && id_rd_we && rd_nz && (rd_q[gi] == id_rd_addr);
      assign alloc_onehot[gi] = alloc_valid && (free_idx == TAG_W'(gi));
    end
  endgenerate

  // Free-slot search uses registered valid, so a slot freed by this cycle's
  // completion only becomes allocatable on the following cycle.
  sb_prio_enc #(
    .W     (DEPTH),
    .IDX_W (TAG_W)
  ) u_free_enc (
    .vec_i (~valid_q),
    .idx_o (free_idx),
    .any_o (any_free)
  );

  assign sb_full    = &valid_q;
  assign struct_haz = long_write && sb_full;
  assign hazard     = id_valid && ((|src_hit) || (|waw_hit) || struct_haz);

  assign alloc_valid = id_valid && long_write && !hazard && !ex_flush && any_free;
  assign alloc_tag   = free_idx;

  // Out-of-range tags decode to no entry, so they also miss here.
  assign cmpl_hit = |(cmpl_sel & valid_q);

  // Pipeline control: flush beats hazard; a hazard holds IF/ID and bubbles ID/EXE.
  always_comb begin
    if_id_mode  = Normal;
    id_exe_mode = Normal;
    if_stall    = Off;
    if (ex_flush) begin
      if_id_mode  = Flush;
      id_exe_mode = Flush;
      if_stall    = Off;
    end else if (hazard) begin
      if_id_mode  = Stall;
      id_exe_mode = Flush;
      if_stall    = On;
    end
  end

  // Next scoreboard, error and counter state.
  always_comb begin
    valid_d        = (valid_q & ~(cmpl_sel & valid_q)) | alloc_onehot;
    cmpl_err_d     = cmpl_err_q || (cmpl_valid && !cmpl_hit);
    stall_cycles_d = stall_cycles_q;
    if (hazard && !ex_flush && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  // State register; reset drops every pending entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= '0;
      cmpl_err_q     <= 1'b0;
      stall_cycles_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      cmpl_err_q     <= cmpl_err_d;
      stall_cycles_q <= stall_cycles_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_onehot[i]) begin
          rd_q[i] <= id_rd_addr;
        end
      end
    end
  end

  assign cmpl_err     = cmpl_err_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed scenarios with
// literal expectations, then randomized traffic against a reference model
// that keeps the pending destinations as a plain per-tag array.
module tb_hazard_scoreboard_unit;
  import hazard_scoreboard_unit_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 6;
  localparam int TAG_W   = 2;
  localparam int G       = GPR_ADDR_SPACE;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                  clk;
  logic                  rst_n;
  logic                  id_valid;
  logic [NUM_SRC*G-1:0]  id_src_addr;
  logic [NUM_SRC-1:0]    id_src_re;
  logic [G-1:0]          id_rd_addr;
  logic                  id_rd_we;
  logic                  id_long_lat;
  logic                  ex_flush;
  logic                  cmpl_valid;
  logic [TAG_W-1:0]      cmpl_tag;
  logic                  alloc_valid;
  logic [TAG_W-1:0]      alloc_tag;
  logic [1:0]            if_id_mode;
  logic [1:0]            id_exe_mode;
  logic                  if_stall;
  logic                  sb_full;
  logic                  cmpl_err;
  logic [CNT_W-1:0]      stall_cycles;

  hazard_scoreboard_unit #(
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_addr  (id_src_addr),
    .id_src_re    (id_src_re),
    .id_rd_addr   (id_rd_addr),
    .id_rd_we     (id_rd_we),
    .id_long_lat  (id_long_lat),
    .ex_flush     (ex_flush),
    .cmpl_valid   (cmpl_valid),
    .cmpl_tag     (cmpl_tag),
    .alloc_valid  (alloc_valid),
    .alloc_tag    (alloc_tag),
    .if_id_mode   (if_id_mode),
    .id_exe_mode  (id_exe_mode),
    .if_stall     (if_stall),
    .sb_full      (sb_full),
    .cmpl_err     (cmpl_err),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // m_pend[t] holds the destination register waiting on tag t, or -1 if free.
  int m_pend [DEPTH];
  bit m_err;
  int m_cnt;

  function automatic int src_of(input int j);
    return int'(id_src_addr[j*G +: G]);
  endfunction

  function automatic bit m_live(input int t);
    return (m_pend[t] >= 0) && !(cmpl_valid && int'(cmpl_tag) == t);
  endfunction

  function automatic bit m_waiting_on(input int r);
    for (int t = 0; t < DEPTH; t++)
      if (m_live(t) && m_pend[t] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_free();
    for (int t = 0; t < DEPTH; t++)
      if (m_pend[t] < 0) return t;
    return -1;
  endfunction

  function automatic bit m_hazard();
    bit src = 1'b0;
    bit waw;
    bit strc;
    int rd = int'(id_rd_addr);
    for (int j = 0; j < NUM_SRC; j++)
      if (id_src_re[j] && src_of(j) != 0 && m_waiting_on(src_of(j))) src = 1'b1;
    waw  = id_rd_we && rd != 0 && m_waiting_on(rd);
    strc = id_long_lat && id_rd_we && rd != 0 && m_free() < 0;
    return id_valid && (src || waw || strc);
  endfunction

  function automatic bit m_alloc();
    return id_valid && id_long_lat && id_rd_we && id_rd_addr != 0
        && !m_hazard() && !ex_flush && m_free() >= 0;
  endfunction

  // Model state advances on the same edge as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < DEPTH; t++) m_pend[t] <= -1;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else begin
      if (cmpl_valid) begin
        if (m_pend[cmpl_tag] >= 0) m_pend[cmpl_tag] <= -1;
        else m_err <= 1'b1;
      end
      if (m_alloc()) m_pend[m_free()] <= int'(id_rd_addr);
      if (m_hazard() && !ex_flush && m_cnt < CNT_SAT) m_cnt <= m_cnt + 1;
    end
  end

  // Every-cycle comparison at mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    logic [1:0] e_ifid;
    logic [1:0] e_idexe;
    bit         e_full;
    e_ifid  = ex_flush ? Flush : (m_hazard() ? Stall : Normal);
    e_idexe = ex_flush ? Flush : (m_hazard() ? Flush : Normal);
    e_full  = (m_free() < 0);
    check("if_id_mode",   32'(if_id_mode),   32'(e_ifid));
    check("id_exe_mode",  32'(id_exe_mode),  32'(e_idexe));
    check("if_stall",     32'(if_stall),     32'(!ex_flush && m_hazard()));
    check("alloc_valid",  32'(alloc_valid),  32'(m_alloc()));
    if (m_alloc()) check("alloc_tag", 32'(alloc_tag), m_free());
    check("sb_full",      32'(sb_full),      32'(e_full));
    check("cmpl_err",     32'(cmpl_err),     32'(m_err));
    check("stall_cycles", 32'(stall_cycles), m_cnt);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int s0, input int s1, input bit [1:0] re,
                       input int rd, input bit we, input bit ll, input bit fl,
                       input bit cv, input int ct);
    id_valid    = v;
    id_src_addr = {G'(s1), G'(s0)};
    id_src_re   = re;
    id_rd_addr  = G'(rd);
    id_rd_we    = we;
    id_long_lat = ll;
    ex_flush    = fl;
    cmpl_valid  = cv;
    cmpl_tag    = TAG_W'(ct);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input string what);
    $display("[%0t] %s", $time, what);
    @(posedge clk);
    #1;
  endtask

  int pend_list [$];

  initial begin
    rst_n = 1'b0;
    idle();
    tick("reset");
    tick("reset");
    check("rst_sb_full",  32'(sb_full), 0);
    check("rst_cnt",      32'(stall_cycles), 0);
    check("rst_err",      32'(cmpl_err), 0);
    check("rst_ifid",     32'(if_id_mode), 32'(Normal));
    rst_n = 1'b1;
    tick("release reset");

    // Load-use: x5 allocated, dependent reads stall 3 cycles, completion releases.
    drive(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0);
    check("lu_alloc_v", 32'(alloc_valid), 1);
    check("lu_alloc_t", 32'(alloc_tag), 0);
    tick("alloc x5");
    for (int k = 0; k < 3; k++) begin
      drive(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 0);
      check("lu_ifid",  32'(if_id_mode), 32'(Stall));
      check("lu_idexe", 32'(id_exe_mode), 32'(Flush));
      check("lu_stall", 32'(if_stall), 1);
      tick("read x5 stalled");
    end
    drive(1, 5, 0, 2'b01, 6, 1, 0, 0, 1, 0);
    check("lu_rel_ifid",  32'(if_id_mode), 32'(Normal));
    check("lu_rel_stall", 32'(if_stall), 0);
    tick("complete tag0, read x5 released");
    idle();
    check("lu_cnt", 32'(stall_cycles), 3);

    // x0 destination never allocates; x0 reads never stall.
    drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
    check("x0_alloc", 32'(alloc_valid), 0);
    check("x0_stall", 32'(if_stall), 0);
    tick("long-lat to x0");
    drive(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);
    check("x0_read", 32'(if_stall), 0);
    tick("read x0");

    // Fill all four entries, then hit the structural hazard.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 0, 0, 2'b00, k + 1, 1, 1, 0, 0, 0);
      check("fill_tag", 32'(alloc_tag), k);
      tick("fill entry");
    end
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0);
    check("full_flag",  32'(sb_full), 1);
    check("full_stall", 32'(if_stall), 1);
    check("full_alloc", 32'(alloc_valid), 0);
    tick("long-lat x7 while full");
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 1, 2);
    check("full_cmpl_stall", 32'(if_stall), 1);
    tick("complete tag2 while full");
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0);
    check("realloc_v", 32'(alloc_valid), 1);
    check("realloc_t", 32'(alloc_tag), 2);
    tick("realloc tag2 for x7");
    idle();
    check("full_cnt", 32'(stall_cycles), 5);

    // Hazard and flush together: flush wins, nothing allocated or counted.
    drive(1, 1, 0, 2'b01, 9, 1, 1, 1, 0, 0);
    check("fl_ifid",  32'(if_id_mode), 32'(Flush));
    check("fl_idexe", 32'(id_exe_mode), 32'(Flush));
    check("fl_stall", 32'(if_stall), 0);
    check("fl_alloc", 32'(alloc_valid), 0);
    tick("hazard with flush");
    idle();
    check("fl_cnt", 32'(stall_cycles), 5);

    // Completion of an invalid entry is sticky-flagged, others untouched.
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
    tick("complete tag3");
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
    tick("complete tag3 again (invalid)");
    idle();
    check("err_set", 32'(cmpl_err), 1);
    drive(1, 1, 2, 2'b11, 0, 0, 0, 0, 0, 0);
    check("err_others", 32'(if_stall), 1);
    tick("read x1/x2 still pending");
    idle();
    tick("idle");
    check("err_sticky", 32'(cmpl_err), 1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      bit cv;
      int ct;
      pend_list.delete();
      for (int t = 0; t < DEPTH; t++) if (m_pend[t] >= 0) pend_list.push_back(t);
      cv = ($urandom_range(0, 2) == 0);
      ct = 0;
      if (cv) begin
        if ($urandom_range(0, 15) == 0 || pend_list.size() == 0) ct = $urandom_range(0, DEPTH - 1);
        else ct = pend_list[$urandom_range(0, pend_list.size() - 1)];
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, cv, ct);
      @(posedge clk);
      #1;
    end

    // Reset mid-traffic with a pending entry and a dependent reader in ID.
    drive(1, 0, 0, 2'b00, 1, 1, 1, 0, 0, 0);
    if (alloc_valid === 1'b0) begin
      idle();
      tick("settle");
      drive(1, 0, 0, 2'b00, 1, 1, 1, 0, 0, 0);
    end
    tick("alloc x1 before reset");
    drive(1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_full",  32'(sb_full), 0);
    check("mrst_cnt",   32'(stall_cycles), 0);
    check("mrst_err",   32'(cmpl_err), 0);
    check("mrst_stall", 32'(if_stall), 0);
    check("mrst_ifid",  32'(if_id_mode), 32'(Normal));
    tick("reset mid-traffic");
    rst_n = 1'b1;
    idle();
    tick("release reset");

    // Counter saturation at all-ones.
    drive(1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0);
    tick("alloc x3");
    drive(1, 3, 3, 2'b11, 0, 0, 0, 0, 0, 0);
    repeat (CNT_SAT + 7) @(posedge clk);
    #1;
    check("sat_cnt",   32'(stall_cycles), CNT_SAT);
    check("sat_stall", 32'(if_stall), 1);
    drive(1, 3, 3, 2'b11, 0, 0, 0, 0, 1, 0);
    tick("complete tag0 after saturation");
    idle();
    tick("idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
